cache_miss_ctrl: RTL and testbench
==================================

# cache_miss_ctrl

Miss-service controller for the cached five-stage pipeline. It arbitrates the single main-memory port between I-cache and D-cache misses, writing back dirty D-cache victims before refilling. It sequences word-by-word line transfers and drives the hold inputs of the PC and the four pipeline registers (IF/ID, ID/EX, EX/M, M/WB) so the whole pipeline freezes until the line is resident.

## Interface
- WORD_BITS, 2, log2 of words per cache line (4 words)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- IM_miss  in  1  I-cache miss, level, held until IM_done
- IM_miss_addr  in  32  byte address of missing instruction
- DM_miss  in  1  D-cache miss, level, held until DM_done
- DM_miss_addr  in  32  byte address of missing data
- DM_dirty  in  1  D-cache victim line dirty (sampled with DM_miss)
- DM_victim_addr  in  32  byte address of victim line
- mem_ready  in  1  memory completes current word transfer this cycle
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write (writeback), 0 = read (fill)
- mem_addr  out  32  word-aligned transfer address
- word_idx  out  WORD_BITS  current word within line
- IM_fill  out  1  I-cache writes memory data into word_idx this cycle
- DM_fill  out  1  D-cache writes memory data into word_idx this cycle
- DM_wb_rd  out  1  D-cache drives victim word word_idx onto memory write data
- IM_done, DM_done  out  1  one-cycle completion pulses
- PCWrite, IFIDWrite, IDEXWrite, EXMWrite, MWBWrite  out  1  active-high HOLD (1 = register keeps value); all five identical

## Operation
- States: IDLE, WB, DFILL, IFILL, DONE. 2-bit word counter cnt, 32-bit line address register line_a, 1-bit src (0 = I, 1 = D).
- IDLE: if DM_miss -> line_a <= DM_miss_addr, src <= 1, cnt <= 0; next WB if DM_dirty (line_a <= DM_victim_addr instead), else DFILL. Else if IM_miss -> line_a <= IM_miss_addr, src <= 0, cnt <= 0, next IFILL. DM wins simultaneous misses (older instruction).
- WB: mem_req=1, mem_we=1, DM_wb_rd=1. On mem_ready: cnt++; on last word (cnt = 2^WORD_BITS-1), line_a <= DM_miss_addr, cnt <= 0, next DFILL.
- DFILL/IFILL: mem_req=1, mem_we=0; DM_fill/IM_fill = mem_ready. On mem_ready cnt++; on last word next DONE.
- DONE: pulse DM_done or IM_done per src; next IDLE. Cache updates tag/valid on this edge and drops its miss line; a still-pending other-side miss is taken from IDLE next.
- mem_addr = {line_a[31:WORD_BITS+2], cnt, 2'b00}; word_idx = cnt. Outside WB/DFILL/IFILL: mem_req, mem_we, fill and wb_rd = 0; mem_addr = 0.
- HOLD = (state != IDLE) | IM_miss | DM_miss, combinational, so the freeze starts in the cycle the miss is raised.
- Miss inputs and addresses are ignored outside IDLE (captured at entry); DM_miss_addr is re-sampled at WB->DFILL and is required stable for the whole service.
- mem_ready is ignored when mem_req = 0; cnt wraps to 0 only via explicit clear.

## Timing
- Reset (async, any state, including mid-transfer): state IDLE, cnt 0, line_a 0, src 0; all outputs 0 except HOLD, which follows the miss inputs. Any partial line is abandoned; the cache re-raises the miss.
- Clean miss, mem_ready constantly 1: miss cycle (IDLE) + 4 fill cycles + DONE = HOLD high 6 cycles.
- Dirty D miss: +4 WB cycles = 10 cycles.
- Each memory wait cycle (mem_req=1, mem_ready=0) adds one cycle; address and control stay stable while waiting.
- Done pulse is exactly one cycle. HOLD drops the cycle after DONE, provided the miss input has dropped.

## Test plan
- Clean DM miss, DM_miss_addr=0x0000_1234, mem_ready=1 -> mem_addr 0x1230,0x1234,0x1238,0x123C with DM_fill=1; DM_done pulse in cycle 5; all HOLDs high for 6 cycles.
- Dirty DM miss, victim 0x0000_8040, miss 0x0000_0040 -> 4 writes (mem_we=1) to 0x8040..0x804C, then 4 reads 0x0040..0x004C; DM_done at cycle 9.
- IM_miss and DM_miss raised in the same cycle -> D line serviced first, DM_done; IM_fill sequence starts 1 cycle after DONE; IM_done follows; HOLD continuous throughout.
- IFILL 0x0000_0100 with mem_ready low for 3 cycles on word 1 -> mem_addr held at 0x0104; IM_fill only on ready cycles; total HOLD 9 cycles.
- rst asserted during DFILL word 2 -> outputs 0 immediately, state IDLE; after release with DM_miss still high, the fill restarts at word 0.
- No misses for 20 cycles -> mem_req=0 and all HOLDs 0 throughout; mem_ready toggling has no effect.

Source files
------------

// File: rtl/cache_miss_ctrl_if.sv
// rtl/cache_miss_ctrl_if.sv - bundle of cache-miss, memory-port and pipeline-hold signals
//
// Purpose: groups every non-clock signal of cache_miss_ctrl.
//   slave  modport: used by the controller (miss/memory-ready inputs, memory/fill/done/hold outputs)
//   master modport: used by the caches, memory and pipeline that surround the controller
// Signals:
//   IM_miss, IM_miss_addr            I-cache miss level and missing byte address
//   DM_miss, DM_miss_addr            D-cache miss level and missing byte address
//   DM_dirty, DM_victim_addr         D-cache victim state and victim line byte address
//   mem_ready                        memory finishes the current word this cycle
//   mem_req, mem_we, mem_addr        memory transfer request, direction, word address
//   word_idx                         word within the line being transferred
//   IM_fill, DM_fill, DM_wb_rd       cache data-array strobes
//   IM_done, DM_done                 one-cycle service completion pulses
//   PCWrite..MWBWrite                pipeline HOLD (1 = register keeps its value)
interface cache_miss_ctrl_if #(
  parameter int WORD_BITS = 2
);
  logic                 IM_miss;
  logic [31:0]          IM_miss_addr;
  logic                 DM_miss;
  logic [31:0]          DM_miss_addr;
  logic                 DM_dirty;
  logic [31:0]          DM_victim_addr;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [WORD_BITS-1:0] word_idx;
  logic                 IM_fill;
  logic                 DM_fill;
  logic                 DM_wb_rd;
  logic                 IM_done;
  logic                 DM_done;
  logic                 PCWrite;
  logic                 IFIDWrite;
  logic                 IDEXWrite;
  logic                 EXMWrite;
  logic                 MWBWrite;

  modport slave (
    input  IM_miss, IM_miss_addr, DM_miss, DM_miss_addr, DM_dirty, DM_victim_addr, mem_ready,
    output mem_req, mem_we, mem_addr, word_idx, IM_fill, DM_fill, DM_wb_rd, IM_done, DM_done,
    output PCWrite, IFIDWrite, IDEXWrite, EXMWrite, MWBWrite
  );

  modport master (
    output IM_miss, IM_miss_addr, DM_miss, DM_miss_addr, DM_dirty, DM_victim_addr, mem_ready,
    input  mem_req, mem_we, mem_addr, word_idx, IM_fill, DM_fill, DM_wb_rd, IM_done, DM_done,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMWrite, MWBWrite
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - I/D cache miss service controller sharing one memory port
//
// Purpose: arbitrates I-cache and D-cache misses onto one word-wide memory port,
//   writes back a dirty D-cache victim line before refilling, sequences the line
//   word by word and freezes the PC and all pipeline registers until the line is in.
// Ports:
//   clk  - clock, all state changes on posedge
//   rst  - asynchronous active-high reset
//   bus  - cache_miss_ctrl_if.slave: miss inputs, memory port, fill/done strobes, HOLDs
module cache_miss_ctrl #(
  parameter int WORD_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  cache_miss_ctrl_if.slave  bus
);

  localparam int LINE_LSB = WORD_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_DFILL,
    S_IFILL,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [WORD_BITS-1:0] cnt_q;
  // Only the line-number bits are kept; word and byte offsets come from cnt_q.
  logic [31:LINE_LSB]   line_q;
  logic                 src_q;    // 0 = I-cache, 1 = D-cache

  logic last_word;
  logic xfer_active;

  assign last_word   = (cnt_q == {WORD_BITS{1'b1}});
  assign xfer_active = (state_q == S_WB) || (state_q == S_DFILL) || (state_q == S_IFILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // The D-side miss belongs to the older instruction, so it wins a tie.
          if (bus.DM_miss) begin
            src_q <= 1'b1;
            cnt_q <= '0;
            if (bus.DM_dirty) begin
              line_q  <= bus.DM_victim_addr[31:LINE_LSB];
              state_q <= S_WB;
            end else begin
              line_q  <= bus.DM_miss_addr[31:LINE_LSB];
              state_q <= S_DFILL;
            end
          end else if (bus.IM_miss) begin
            src_q   <= 1'b0;
            cnt_q   <= '0;
            line_q  <= bus.IM_miss_addr[31:LINE_LSB];
            state_q <= S_IFILL;
          end
        end
        S_WB: begin
          if (bus.mem_ready) begin
            if (last_word) begin
              // Victim is out; switch the line address to the refill target.
              line_q  <= bus.DM_miss_addr[31:LINE_LSB];
              cnt_q   <= '0;
              state_q <= S_DFILL;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DFILL, S_IFILL: begin
          if (bus.mem_ready) begin
            if (last_word) begin
              cnt_q   <= '0;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  logic hold;

  // Misses feed HOLD directly so the pipeline freezes in the very cycle a miss appears.
  assign hold = (state_q != S_IDLE) || bus.IM_miss || bus.DM_miss;

  assign bus.mem_req   = xfer_active;
  assign bus.mem_we    = (state_q == S_WB);
  assign bus.mem_addr  = xfer_active ? {line_q, cnt_q, 2'b00} : 32'h0;
  assign bus.word_idx  = cnt_q;
  assign bus.IM_fill   = (state_q == S_IFILL) && bus.mem_ready;
  assign bus.DM_fill   = (state_q == S_DFILL) && bus.mem_ready;
  assign bus.DM_wb_rd  = (state_q == S_WB);
  assign bus.IM_done   = (state_q == S_DONE) && !src_q;
  assign bus.DM_done   = (state_q == S_DONE) && src_q;
  assign bus.PCWrite   = hold;
  assign bus.IFIDWrite = hold;
  assign bus.IDEXWrite = hold;
  assign bus.EXMWrite  = hold;
  assign bus.MWBWrite  = hold;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - self-checking bench for cache_miss_ctrl
module tb_cache_miss_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cache_miss_ctrl_if #(.WORD_BITS(2)) bus ();

  cache_miss_ctrl #(.WORD_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Observed output vector: {req, we, addr, idx, im_fill, dm_fill, wb_rd, im_done, dm_done, hold x5}
  function automatic logic [45:0] obs();
    return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.word_idx, bus.IM_fill, bus.DM_fill,
            bus.DM_wb_rd, bus.IM_done, bus.DM_done, bus.PCWrite, bus.IFIDWrite,
            bus.IDEXWrite, bus.EXMWrite, bus.MWBWrite};
  endfunction

  function automatic logic [45:0] expv(input logic req, input logic we, input logic [31:0] a,
                                       input logic imf, input logic dmf, input logic wb,
                                       input logic imd, input logic dmd, input logic hold);
    return {req, we, a, a[3:2], imf, dmf, wb, imd, dmd, {5{hold}}};
  endfunction

  // Services one miss starting in a cycle where the controller is idle and the miss is
  // visible (called #1 after a negedge). The expected transfer list is built up front
  // from the line rules; each cycle then consumes it as memory accepts words.
  task automatic service(input bit is_d, input bit dirty, input logic [31:0] victim,
                         input logic [31:0] maddr, input bit rnd, input int stall_word,
                         input int stall_n, output int hold_cyc, output int waits);
    logic [31:0] q_addr[$];
    bit          q_we[$];
    logic [45:0] e;
    logic [31:0] a;
    int          k;
    int          w_try;
    hold_cyc = 0;
    waits    = 0;
    k        = 0;
    w_try    = 0;
    if (is_d && dirty)
      for (int w = 0; w < 4; w++) begin
        q_addr.push_back({victim[31:4], 2'(w), 2'b00});
        q_we.push_back(1'b1);
      end
    for (int w = 0; w < 4; w++) begin
      q_addr.push_back({maddr[31:4], 2'(w), 2'b00});
      q_we.push_back(1'b0);
    end

    e = expv(0, 0, 32'h0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL capture: got %h expected %h", obs(), e);
    end
    hold_cyc = 1;

    while (q_addr.size() > 0) begin
      @(negedge clk);
      // Victim info is only meaningful at capture; wiggle it to prove it is ignored.
      bus.DM_dirty       = 1'($urandom);
      bus.DM_victim_addr = $urandom;
      if (rnd) bus.mem_ready = ($urandom_range(0, 99) < 55) || (w_try >= 4);
      else     bus.mem_ready = !(((k % 4) == stall_word) && (w_try < stall_n));
      #1;
      a = q_addr[0];
      e = expv(1, q_we[0], a, !is_d && !q_we[0] && bus.mem_ready,
               is_d && !q_we[0] && bus.mem_ready, q_we[0], 0, 0, 1);
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL xfer%0d: got %h expected %h", k, obs(), e);
      end
      hold_cyc++;
      if (bus.mem_ready) begin
        void'(q_addr.pop_front());
        void'(q_we.pop_front());
        k++;
        w_try = 0;
      end else begin
        waits++;
        w_try++;
      end
    end

    @(negedge clk);
    bus.mem_ready = 1'($urandom);
    #1;
    e = expv(0, 0, 32'h0, 0, 0, 0, !is_d, is_d, 1);
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL done_pulse: got %h expected %h", obs(), e);
    end
    hold_cyc++;

    // The cache drops its miss on the DONE edge.
    @(negedge clk);
    if (is_d) bus.DM_miss = 1'b0;
    else      bus.IM_miss = 1'b0;
    bus.mem_ready = 1'($urandom);
    #1;
    e = expv(0, 0, 32'h0, 0, 0, 0, 0, 0, bus.IM_miss | bus.DM_miss);
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL after_done: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_reset();
    logic [45:0] e;
    rst = 1'b1;
    bus.IM_miss = 0; bus.DM_miss = 0; bus.DM_dirty = 0; bus.mem_ready = 0;
    bus.IM_miss_addr = 0; bus.DM_miss_addr = 0; bus.DM_victim_addr = 0;
    @(negedge clk);
    #1;
    e = expv(0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", obs(), e);
    end
    bus.DM_miss = 1'b1;
    #1;
    e = expv(0, 0, 32'h0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL reset_hold_follows_miss: got %h expected %h", obs(), e);
    end
    bus.DM_miss = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_dm();
    int h, wt;
    @(negedge clk);
    bus.DM_miss = 1; bus.DM_miss_addr = 32'h0000_1234; bus.DM_dirty = 0;
    bus.DM_victim_addr = 32'hdead_beef; bus.mem_ready = 1;
    #1;
    service(1, 0, 32'hdead_beef, 32'h0000_1234, 0, -1, 0, h, wt);
    n_cmp++;
    if (h !== 6) begin
      n_err++;
      $display("FAIL clean_dm_hold_cycles: got %0d expected 6", h);
    end
  endtask

  task automatic test_dirty_dm();
    int h, wt;
    @(negedge clk);
    bus.DM_miss = 1; bus.DM_miss_addr = 32'h0000_0040; bus.DM_dirty = 1;
    bus.DM_victim_addr = 32'h0000_8040; bus.mem_ready = 1;
    #1;
    service(1, 1, 32'h0000_8040, 32'h0000_0040, 0, -1, 0, h, wt);
    n_cmp++;
    if (h !== 10) begin
      n_err++;
      $display("FAIL dirty_dm_hold_cycles: got %0d expected 10", h);
    end
  endtask

  task automatic test_simultaneous();
    int h1, h2, wt;
    logic [31:0] ia, da;
    ia = $urandom; da = $urandom;
    @(negedge clk);
    bus.IM_miss = 1; bus.IM_miss_addr = ia;
    bus.DM_miss = 1; bus.DM_miss_addr = da; bus.DM_dirty = 0; bus.mem_ready = 1;
    #1;
    service(1, 0, 32'h0, da, 0, -1, 0, h1, wt);
    service(0, 0, 32'h0, ia, 0, -1, 0, h2, wt);
    n_cmp++;
    if (h1 + h2 !== 12) begin
      n_err++;
      $display("FAIL simultaneous_hold_cycles: got %0d expected 12", h1 + h2);
    end
  endtask

  task automatic test_stall();
    int h, wt;
    @(negedge clk);
    bus.IM_miss = 1; bus.IM_miss_addr = 32'h0000_0100; bus.mem_ready = 1;
    #1;
    service(0, 0, 32'h0, 32'h0000_0100, 0, 1, 3, h, wt);
    n_cmp++;
    if (h !== 9 || wt !== 3) begin
      n_err++;
      $display("FAIL stall_hold_cycles: got %0d/%0d expected 9/3", h, wt);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [45:0] e;
    int h, wt;
    @(negedge clk);
    bus.DM_miss = 1; bus.DM_miss_addr = 32'h0000_5670; bus.DM_dirty = 0; bus.mem_ready = 1;
    #1;
    repeat (3) @(negedge clk);
    #1;
    e = expv(1, 0, 32'h0000_5678, 0, 1, 0, 0, 0, 1);
    n_cmp++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL pre_reset_word2: got %h expected %h", obs(), e);
    end
    rst = 1'b1;
    #1;
    e = expv(0, 0, 32'h0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL reset_mid_fill%0d: got %h expected %h", i, obs(), e);
      end
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    service(1, 0, 32'h0, 32'h0000_5670, 0, -1, 0, h, wt);
    n_cmp++;
    if (h !== 6) begin
      n_err++;
      $display("FAIL restart_hold_cycles: got %0d expected 6", h);
    end
  endtask

  task automatic test_idle();
    logic [45:0] e;
    e = expv(0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.IM_miss = 0; bus.DM_miss = 0;
      bus.mem_ready = i[0];
      bus.IM_miss_addr = $urandom; bus.DM_miss_addr = $urandom; bus.DM_dirty = 1'($urandom);
      #1;
      n_cmp++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL idle%0d: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_random();
    int kind, h, wt, h2, wt2;
    bit dirty;
    logic [31:0] ia, da, va;
    for (int it = 0; it < 25; it++) begin
      kind = $urandom_range(0, 2);
      dirty = 1'($urandom);
      ia = $urandom; da = $urandom; va = $urandom;
      @(negedge clk);
      bus.IM_miss = (kind != 0); bus.IM_miss_addr = ia;
      bus.DM_miss = (kind != 1); bus.DM_miss_addr = da;
      bus.DM_dirty = dirty; bus.DM_victim_addr = va;
      bus.mem_ready = 1'($urandom);
      #1;
      if (kind != 1) begin
        service(1, dirty, va, da, 1, -1, 0, h, wt);
        n_cmp++;
        if (h !== 2 + (dirty ? 8 : 4) + wt) begin
          n_err++;
          $display("FAIL rand%0d_d_hold: got %0d expected %0d", it, h, 2 + (dirty ? 8 : 4) + wt);
        end
      end
      if (kind != 0) begin
        service(0, 0, 32'h0, ia, 1, -1, 0, h2, wt2);
        n_cmp++;
        if (h2 !== 6 + wt2) begin
          n_err++;
          $display("FAIL rand%0d_i_hold: got %0d expected %0d", it, h2, 6 + wt2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_dm();
    test_dirty_dm();
    test_simultaneous();
    test_stall();
    test_reset_mid_fill();
    test_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
